// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_sel_e;

  // Number of radix-4 digits needed to cover a WIDTH-bit operand plus extension.
  function automatic int unsigned booth_steps(input int unsigned width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoding of one 3-bit multiplier window into a digit select.
import mult_pkg::*;

module booth_r4_encoder (
  input  logic [2:0] win,
  output booth_sel_e sel_c
);

  always_comb begin
    sel_c = ZERO;
    unique case (win)
      3'b001, 3'b010: sel_c = POS1;
      3'b011:         sel_c = POS2;
      3'b100:         sel_c = NEG2;
      3'b101, 3'b110: sel_c = NEG1;
      default:        sel_c = ZERO;
    endcase
  end

endmodule

// File: rtl/prefix_tree_adder.sv
// Kogge-Stone style parallel-prefix adder with carry-in; carry-out is dropped.
module prefix_tree_adder #(
  parameter int unsigned W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c
);

  // Only carries into bits 1..W-1 are needed, so the tree spans W-1 bits.
  localparam int unsigned CW = W - 1;

  logic [W-1:0]  hs;
  logic [CW-1:0] g;
  logic [CW-1:0] p;

  assign hs = a ^ b;

  // Descending inner loop lets g/p be updated in place: g[i-d] is still the previous level.
  always_comb begin
    g    = a[CW-1:0] & b[CW-1:0];
    p    = hs[CW-1:0];
    g[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < int'(CW); d = d * 2) begin
      for (int i = int'(CW) - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
  end

  assign sum_c = hs ^ {g, cin};

endmodule

// File: rtl/booth_seq_multiplier.sv
// Multi-cycle radix-4 Booth multiplier, one partial product per clock,
// valid/ready handshakes on operand and result sides.
import mult_pkg::*;

module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_res,
  output logic               busy
);

  localparam int unsigned AW = 2 * WIDTH + 2;
  localparam int unsigned BW = WIDTH + 3;
  localparam int unsigned N  = booth_steps(WIDTH);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_seq_multiplier: WIDTH must be even and >= 4");
  end

  state_e      state, state_d;
  logic [AW-1:0] a_sh;
  logic [BW-1:0] b_sh;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          load, step, fin;
  booth_sel_e    sel_c;
  logic [AW-1:0] pp_c;
  logic          neg_c;
  logic [AW-1:0] sum_c;
  logic          a_ext, b_ext;

  assign a_ext = in_signed & in_a[WIDTH-1];
  assign b_ext = in_signed & in_b[WIDTH-1];

  // Current digit window sits at the bottom of the right-shifting multiplier register.
  booth_r4_encoder u_enc (
    .win  (b_sh[2:0]),
    .sel_c(sel_c)
  );

  // Multiplicand register is pre-shifted by 2i, so the digit only picks a multiple.
  always_comb begin
    pp_c  = '0;
    neg_c = 1'b0;
    unique case (sel_c)
      POS1: pp_c = a_sh;
      POS2: pp_c = AW'(a_sh << 1);
      NEG1: begin
        pp_c  = ~a_sh;
        neg_c = 1'b1;
      end
      NEG2: begin
        pp_c  = ~(AW'(a_sh << 1));
        neg_c = 1'b1;
      end
      default: pp_c = '0;
    endcase
  end

  prefix_tree_adder #(.W(AW)) u_add (
    .a    (acc),
    .b    (pp_c),
    .cin  (neg_c),
    .sum_c(sum_c)
  );

  // Control: next state and datapath enables.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == CW'(N - 1)) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and handshake flags, decoded from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d == BUSY);
      out_valid <= (state_d == DONE);
    end
  end

  // Operand, accumulator and digit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= {{(AW - WIDTH){a_ext}}, in_a};
      b_sh <= {{2{b_ext}}, in_b, 1'b0};
      acc  <= '0;
      cnt  <= '0;
    end else if (step) begin
      acc  <= sum_c;
      a_sh <= AW'(a_sh << 2);
      b_sh <= BW'(b_sh >> 2);
      cnt  <= cnt + CW'(1);
    end
  end

  // Result register holds its value after handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_res <= '0;
    end else if (fin) begin
      out_res <= sum_c[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier at WIDTH 8, plus WIDTH 4 and 16 instances.
module tb_booth_seq_multiplier;

  logic        clk;
  logic        rst_n;
  int          checks;
  int          errors;
  int          cyc;

  // WIDTH = 8
  logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_res;

  // WIDTH = 4
  logic        v4, rdy4, s4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  r4;

  // WIDTH = 16
  logic        v16, rdy16, s16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] r16;

  booth_seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .busy(busy)
  );

  booth_seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
    .in_a(a4), .in_b(b4), .in_signed(s4), .out_valid(ov4),
    .out_ready(or4), .out_res(r4), .busy(busy4)
  );

  booth_seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .in_a(a16), .in_b(b16), .in_signed(s16), .out_valid(ov16),
    .out_ready(or16), .out_res(r16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand pair on the WIDTH-8 port, wait for the product, check value and latency.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string tag);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    check({tag, " in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, out_valid, 1'b1);
    check({tag, " res"}, out_res, exp);
    check({tag, " latency"}, 64'(n), 64'd6);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [7:0] ea, eb, e;
    int n;
    ea = s ? {{4{a[3]}}, a} : {4'd0, a};
    eb = s ? {{4{b[3]}}, b} : {4'd0, b};
    e  = 8'(ea * eb);
    @(negedge clk);
    a4 = a; b4 = b; s4 = s; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w4 res", {ov4, r4}, {1'b1, e});
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input int stall);
    logic [31:0] ea, eb, e;
    int n;
    ea = s ? {{16{a[15]}}, a} : {16'd0, a};
    eb = s ? {{16{b[15]}}, b} : {16'd0, b};
    e  = 32'(ea * eb);
    @(negedge clk);
    a16 = a; b16 = b; s16 = s; v16 = 1'b1; or16 = 1'b0;
    @(negedge clk);
    v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (stall) @(negedge clk);
    check("w16 res", {ov16, r16}, {1'b1, e});
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
  endtask

  logic [7:0]  bb_a [5] = '{8'h03, 8'hFE, 8'h10, 8'h7F, 8'h80};
  logic [7:0]  bb_b [5] = '{8'h05, 8'h03, 8'h10, 8'h7F, 8'h01};
  logic        bb_s [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] bb_e [5] = '{16'h000F, 16'hFFFA, 16'h0100, 16'h3F01, 16'hFF80};

  initial begin
    int acc_i, res_i, last_acc;
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; or16 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset out_res", out_res, 16'h0000);
    rst_n = 1'b1;

    // Unsigned MAX*MAX with latency, then held under backpressure
    out_ready = 1'b0;
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u ff*ff");
    for (int k = 0; k < 10; k++) begin
      in_a = 8'h11; in_b = 8'h22; in_valid = 1'b1;
      @(negedge clk);
      check("stall valid", out_valid, 1'b1);
      check("stall res", out_res, 16'hFE01);
      check("stall in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release valid", out_valid, 1'b0);
    check("release in_ready", in_ready, 1'b1);
    check("release res held", out_res, 16'hFE01);
    @(negedge clk);
    check("release busy", busy, 1'b0);

    // Signed corners and mode dependence
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s 80*80");
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s 80*7f");
    op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s ff*01");
    op8(8'hFF, 8'h01, 1'b0, 16'h00FF, "u ff*01");
    op8(8'h00, 8'hA5, 1'b1, 16'h0000, "s 00*a5");

    // Reset in the third BUSY cycle
    @(negedge clk);
    in_a = 8'h55; in_b = 8'h66; in_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h12, 8'h34, 1'b0, 16'h03A8, "u 12*34");

    // Back-to-back with in_valid held high
    acc_i = 0; res_i = 0; last_acc = 0;
    @(negedge clk);
    for (int t = 0; t < 60 && res_i < 5; t++) begin
      if (acc_i < 5) begin
        in_a = bb_a[acc_i]; in_b = bb_b[acc_i]; in_signed = bb_s[acc_i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        check("b2b res", out_res, bb_e[res_i]);
        res_i++;
      end
      if (in_valid && in_ready) begin
        if (acc_i > 0) check("b2b period", 64'(cyc - last_acc), 64'd7);
        last_acc = cyc;
        acc_i++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b results", 64'(res_i), 64'd5);
    repeat (3) begin
      @(negedge clk);
      check("b2b no extra", out_valid, 1'b0);
    end

    // WIDTH 4: every operand pair in both modes
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      op4(iv[3:0], iv[7:4], iv[8]);
    end

    // WIDTH 16: random operands, modes and result stalls, plus corners
    op16(16'h8000, 16'h8000, 1'b1, 0);
    op16(16'hFFFF, 16'hFFFF, 1'b0, 1);
    op16(16'hFFFF, 16'hFFFF, 1'b1, 0);
    for (int i = 0; i < 300; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
